// File: rtl/cpu_ctrl_pkg.sv
// Shared encodings for the CPU step controller: front-panel mode values and controller states.
package cpu_ctrl_pkg;

  localparam logic [2:0] MODE_RUN   = 3'd0;
  localparam logic [2:0] MODE_DIV   = 3'd1;
  localparam logic [2:0] MODE_STEP  = 3'd2;
  localparam logic [2:0] MODE_BURST = 3'd3;
  localparam logic [2:0] MODE_HALT  = 3'd4;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    STEP,
    BP_HALT
  } state_t;

  function automatic logic is_run_mode(input logic [2:0] m);
    return (m == MODE_RUN) || (m == MODE_DIV);
  endfunction

  function automatic logic is_step_mode(input logic [2:0] m);
    return (m == MODE_STEP) || (m == MODE_BURST);
  endfunction

  function automatic logic is_halt_mode(input logic [2:0] m);
    return m >= MODE_HALT;
  endfunction

endpackage

// File: rtl/btn_debounce.sv
// Push-button conditioner: 2-flop synchroniser, stability debounce and a one-cycle press pulse.
module btn_debounce #(
  parameter int DB_CYCLES = 50000,
  parameter int DB_W      = 16
) (
  input  logic CLK,
  input  logic RST,
  input  logic btn,
  output logic press
);

  localparam logic [DB_W-1:0] DB_LAST = DB_W'(DB_CYCLES - 1);

  logic            sync1_reg;
  logic            sync2_reg;
  logic            stable_reg;
  logic            press_reg;
  logic [DB_W-1:0] cnt_reg;

  // Button is active-low, so the idle (released) level is 1.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      sync1_reg  <= 1'b1;
      sync2_reg  <= 1'b1;
      stable_reg <= 1'b1;
      press_reg  <= 1'b0;
      cnt_reg    <= '0;
    end else begin
      sync1_reg <= btn;
      sync2_reg <= sync1_reg;
      press_reg <= 1'b0;
      if (sync2_reg == stable_reg) begin
        cnt_reg <= '0;
      end else if (cnt_reg == DB_LAST) begin
        cnt_reg    <= '0;
        stable_reg <= sync2_reg;
        press_reg  <= stable_reg;
      end else begin
        cnt_reg <= cnt_reg + 1'b1;
      end
    end
  end

  assign press = press_reg;

endmodule

// File: rtl/cpu_step_ctrl.sv
// Clock-enable / single-step controller: issues paired mem_ce then cpu_ce pulses per step,
// in free-run, divided-run, single-step and burst modes, with a PC breakpoint halt.
module cpu_step_ctrl
  import cpu_ctrl_pkg::*;
#(
  parameter int DIV_W     = 26,
  parameter int DB_CYCLES = 50000,
  parameter int DB_W      = 16,
  parameter int BURST_W   = 8,
  parameter int ADDR_W    = 16
) (
  input  logic               CLK,
  input  logic               RST,
  input  logic [2:0]         mode,
  input  logic [4:0]         div_sel,
  input  logic               button,
  input  logic [BURST_W-1:0] burst_len,
  input  logic               bp_en,
  input  logic [ADDR_W-1:0]  bp_addr,
  input  logic [ADDR_W-1:0]  pc,
  input  logic               resume,
  output logic               mem_ce,
  output logic               cpu_ce,
  output logic               running,
  output logic               bp_hit,
  output logic [15:0]        step_count
);

  state_t             state_reg, state_next;
  logic               phase_reg, phase_next;
  logic [BURST_W-1:0] remaining_reg, remaining_next;
  logic               skip_bp_reg, skip_bp_next;
  logic               mem_ce_reg, mem_ce_next;
  logic               cpu_ce_reg, cpu_ce_next;
  logic [15:0]        step_count_reg;
  logic [DIV_W-1:0]   div_reg;
  logic               tap_prev_reg;

  logic               press;
  logic [4:0]         tap_sel;
  logic [DIV_W-1:0]   tap_hit;
  logic               tap_bit;
  logic               slot;
  logic               bp_match;
  logic               issue;
  logic [BURST_W-1:0] burst_load;

  btn_debounce #(
    .DB_CYCLES (DB_CYCLES),
    .DB_W      (DB_W)
  ) u_btn (
    .CLK   (CLK),
    .RST   (RST),
    .btn   (button),
    .press (press)
  );

  assign tap_sel = (int'(div_sel) > DIV_W - 1) ? 5'(DIV_W - 1) : div_sel;

  for (genvar gi = 0; gi < DIV_W; gi++) begin : g_tap
    assign tap_hit[gi] = (int'(tap_sel) == gi);
  end

  assign tap_bit    = |(div_reg & tap_hit);
  assign slot       = (mode == MODE_RUN) || (tap_bit && !tap_prev_reg);
  assign bp_match   = bp_en && (pc == bp_addr);
  assign burst_load = (mode == MODE_BURST && burst_len != '0) ? burst_len : BURST_W'(1);

  always_comb begin
    state_next     = state_reg;
    phase_next     = phase_reg;
    remaining_next = remaining_reg;
    skip_bp_next   = skip_bp_reg;
    mem_ce_next    = 1'b0;
    cpu_ce_next    = 1'b0;
    issue          = 1'b0;

    if (phase_reg) begin
      // A started step always completes, whatever the state or mode.
      if (slot) begin
        cpu_ce_next = 1'b1;
        phase_next  = 1'b0;
        if (state_reg == STEP) begin
          remaining_next = remaining_reg - 1'b1;
          if (remaining_reg <= BURST_W'(1)) state_next = IDLE;
        end
      end
    end else begin
      case (state_reg)
        IDLE: begin
          if (is_run_mode(mode)) begin
            state_next = RUN;
            issue      = 1'b1;
          end else if (is_step_mode(mode) && press) begin
            state_next     = STEP;
            remaining_next = burst_load;
            skip_bp_next   = 1'b0;
          end
        end
        RUN: begin
          if (is_run_mode(mode)) issue = 1'b1;
          else state_next = IDLE;
        end
        STEP: begin
          if (is_halt_mode(mode)) state_next = IDLE;
          else issue = 1'b1;
        end
        BP_HALT: begin
          if (resume) begin
            state_next     = STEP;
            remaining_next = BURST_W'(1);
            skip_bp_next   = 1'b1;
          end else if (is_halt_mode(mode)) begin
            state_next = IDLE;
          end
        end
        default: state_next = IDLE;
      endcase

      // The post-resume step must ignore the breakpoint so the core can leave bp_addr.
      if (issue && slot) begin
        if (bp_match && !(skip_bp_reg && state_reg == STEP)) begin
          state_next = BP_HALT;
        end else begin
          mem_ce_next  = 1'b1;
          phase_next   = 1'b1;
          skip_bp_next = 1'b0;
        end
      end
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_reg      <= IDLE;
      phase_reg      <= 1'b0;
      remaining_reg  <= '0;
      skip_bp_reg    <= 1'b0;
      mem_ce_reg     <= 1'b0;
      cpu_ce_reg     <= 1'b0;
      step_count_reg <= '0;
      div_reg        <= '0;
      tap_prev_reg   <= 1'b0;
    end else begin
      state_reg     <= state_next;
      phase_reg     <= phase_next;
      remaining_reg <= remaining_next;
      skip_bp_reg   <= skip_bp_next;
      mem_ce_reg    <= mem_ce_next;
      cpu_ce_reg    <= cpu_ce_next;
      div_reg       <= div_reg + 1'b1;
      tap_prev_reg  <= tap_bit;
      if (cpu_ce_next) step_count_reg <= step_count_reg + 16'd1;
    end
  end

  assign mem_ce     = mem_ce_reg;
  assign cpu_ce     = cpu_ce_reg;
  assign running    = (state_reg == RUN) || (state_reg == STEP);
  assign bp_hit     = (state_reg == BP_HALT);
  assign step_count = step_count_reg;

endmodule

// File: tb/tb_cpu_step_ctrl.sv
// Self-checking bench for cpu_step_ctrl: table of mode scenarios plus hand-written corner sequences.
module tb_cpu_step_ctrl;

  logic        CLK;
  logic        RST;
  logic [2:0]  mode;
  logic [4:0]  div_sel;
  logic        button;
  logic [7:0]  burst_len;
  logic        bp_en;
  logic [15:0] bp_addr;
  logic [15:0] pc;
  logic        resume;
  logic        mem_ce;
  logic        cpu_ce;
  logic        running;
  logic        bp_hit;
  logic [15:0] step_count;

  cpu_step_ctrl #(
    .DIV_W     (6),
    .DB_CYCLES (4),
    .DB_W      (4),
    .BURST_W   (8),
    .ADDR_W    (16)
  ) dut (
    .CLK        (CLK),
    .RST        (RST),
    .mode       (mode),
    .div_sel    (div_sel),
    .button     (button),
    .burst_len  (burst_len),
    .bp_en      (bp_en),
    .bp_addr    (bp_addr),
    .pc         (pc),
    .resume     (resume),
    .mem_ce     (mem_ce),
    .cpu_ce     (cpu_ce),
    .running    (running),
    .bp_hit     (bp_hit),
    .step_count (step_count)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  typedef struct {
    logic [2:0] mode;
    logic [4:0] div_sel;
    logic [7:0] burst_len;
    bit         do_press;
    int         cycles;
    int         exp_mem;
    int         exp_cpu;
    int         exp_sc;
    int         exp_run;
  } vec_t;

  typedef struct {
    int mem;
    int cpu;
    int sc;
    int run;
  } exp_t;

  vec_t vecs[8];
  exp_t sb_q[$];

  int checks      = 0;
  int failures    = 0;
  int mem_cnt     = 0;
  int cpu_cnt     = 0;
  int overlap_cnt = 0;
  int cyc         = 0;
  bit pc_follow   = 0;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // One clock; outputs sampled on the falling edge. pc models a core advancing on cpu_ce.
  task automatic tick();
    @(negedge CLK);
    cyc++;
    if (mem_ce) mem_cnt++;
    if (cpu_ce) begin
      cpu_cnt++;
      if (pc_follow) pc = pc + 16'd1;
    end
    if (mem_ce && cpu_ce) overlap_cnt++;
  endtask

  task automatic do_reset();
    RST       = 1'b1;
    mode      = 3'd4;
    div_sel   = 5'd0;
    button    = 1'b1;
    burst_len = 8'd0;
    bp_en     = 1'b0;
    bp_addr   = 16'd0;
    pc        = 16'd0;
    resume    = 1'b0;
    pc_follow = 1'b0;
    repeat (2) @(negedge CLK);
    check("reset_outputs", int'({mem_ce, cpu_ce, running, bp_hit, step_count}), 0);
    RST     = 1'b0;
    mem_cnt = 0;
    cpu_cnt = 0;
    cyc     = 0;
  endtask

  function automatic logic btn_wave(input int i);
    if (i < 2)  return 1'b0;
    if (i < 4)  return 1'b1;
    if (i < 16) return 1'b0;
    if (i < 24) return 1'b1;
    if (i < 32) return 1'b0;
    return 1'b1;
  endfunction

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    exp_t e;
    int t_mem, t_cpu1, t_cpu2, n;

    RST = 1'b1;
    //          mode  div    len   press cyc  mem cpu sc run
    vecs[0] = '{3'd0, 5'd0, 8'd0, 1'b0, 20,  10, 10, 10, 1};
    vecs[1] = '{3'd1, 5'd2, 8'd0, 1'b0, 64,  4,  4,  4,  1};
    vecs[2] = '{3'd1, 5'd9, 8'd0, 1'b0, 130, 1,  1,  1,  1};
    vecs[3] = '{3'd3, 5'd0, 8'd5, 1'b1, 80,  5,  5,  5,  0};
    vecs[4] = '{3'd3, 5'd0, 8'd0, 1'b1, 40,  1,  1,  1,  0};
    vecs[5] = '{3'd2, 5'd0, 8'd9, 1'b1, 40,  1,  1,  1,  0};
    vecs[6] = '{3'd2, 5'd0, 8'd0, 1'b0, 40,  0,  0,  0,  0};
    vecs[7] = '{3'd5, 5'd0, 8'd0, 1'b1, 40,  0,  0,  0,  0};

    for (int i = 0; i < 8; i++) begin
      do_reset();
      mode      = vecs[i].mode;
      div_sel   = vecs[i].div_sel;
      burst_len = vecs[i].burst_len;
      sb_q.push_back('{vecs[i].exp_mem, vecs[i].exp_cpu, vecs[i].exp_sc, vecs[i].exp_run});
      for (int c = 0; c < vecs[i].cycles; c++) begin
        button = (vecs[i].do_press && c < 8) ? 1'b0 : 1'b1;
        tick();
      end
      e = sb_q.pop_front();
      $display("vec %0d mode=%0d div=%0d len=%0d mem=%0d cpu=%0d sc=%0d run=%0d",
               i, mode, div_sel, burst_len, mem_cnt, cpu_cnt, step_count, running);
      check($sformatf("vec%0d_mem", i), mem_cnt, e.mem);
      check($sformatf("vec%0d_cpu", i), cpu_cnt, e.cpu);
      check($sformatf("vec%0d_step_count", i), int'(step_count), e.sc);
      check($sformatf("vec%0d_running", i), int'(running), e.run);
    end

    // Free-run: strict alternation starting with mem_ce on the first cycle.
    do_reset();
    mode = 3'd0;
    for (int i = 0; i < 4; i++) begin
      tick();
      check($sformatf("alt%0d_mem", i), int'(mem_ce), (i % 2 == 0) ? 1 : 0);
      check($sformatf("alt%0d_cpu", i), int'(cpu_ce), (i % 2 == 1) ? 1 : 0);
    end
    $display("seq alternate mem=%0d cpu=%0d", mem_cnt, cpu_cnt);

    // Divided run: 8 cycles mem->cpu, 16 cycles cpu->cpu.
    do_reset();
    mode    = 3'd1;
    div_sel = 5'd2;
    t_mem = -1; t_cpu1 = -1; t_cpu2 = -1;
    for (int i = 0; i < 64; i++) begin
      tick();
      if (mem_ce && t_mem < 0) t_mem = cyc;
      if (cpu_ce) begin
        if (t_cpu1 < 0) t_cpu1 = cyc;
        else if (t_cpu2 < 0) t_cpu2 = cyc;
      end
    end
    $display("seq divided mem@%0d cpu@%0d cpu@%0d", t_mem, t_cpu1, t_cpu2);
    check("div_mem_to_cpu", t_cpu1 - t_mem, 8);
    check("div_cpu_period", t_cpu2 - t_cpu1, 16);

    // Bouncing press, then a second press while the step is still pending.
    do_reset();
    mode    = 3'd2;
    div_sel = 5'd4;
    sb_q.push_back('{1, 1, 1, 0});
    for (int i = 0; i < 200; i++) begin
      button = btn_wave(i);
      tick();
      if (i == 30) check("bounce_running_mid", int'(running), 1);
    end
    e = sb_q.pop_front();
    $display("seq debounce mem=%0d cpu=%0d sc=%0d", mem_cnt, cpu_cnt, step_count);
    check("bounce_mem", mem_cnt, e.mem);
    check("bounce_cpu", cpu_cnt, e.cpu);
    check("bounce_step_count", int'(step_count), e.sc);
    check("bounce_running", int'(running), e.run);

    // Breakpoint at pc 4, then resume issues exactly one step.
    do_reset();
    mode      = 3'd0;
    bp_en     = 1'b1;
    bp_addr   = 16'h0004;
    pc_follow = 1'b1;
    n = 0;
    while (!bp_hit && n < 40) begin
      tick();
      n++;
    end
    $display("seq breakpoint pc=%0d bp_hit=%0d mem=%0d cpu=%0d", pc, bp_hit, mem_cnt, cpu_cnt);
    check("bp_hit_set", int'(bp_hit), 1);
    check("bp_pc", int'(pc), 4);
    check("bp_mem_before", mem_cnt, 4);
    mode = 3'd2;
    repeat (6) tick();
    check("bp_hold_mem", mem_cnt, 4);
    check("bp_hold_running", int'(running), 0);
    resume = 1'b1;
    tick();
    resume = 1'b0;
    repeat (20) tick();
    $display("seq resume pc=%0d bp_hit=%0d mem=%0d cpu=%0d", pc, bp_hit, mem_cnt, cpu_cnt);
    check("resume_mem", mem_cnt, 5);
    check("resume_cpu", cpu_cnt, 5);
    check("resume_bp_hit", int'(bp_hit), 0);
    check("resume_running", int'(running), 0);

    // Mode drops to halt between mem_ce and cpu_ce: the step still completes.
    do_reset();
    mode = 3'd0;
    tick();
    check("halt_mid_mem", int'(mem_ce), 1);
    mode    = 3'd4;
    mem_cnt = 0;
    cpu_cnt = 0;
    repeat (20) tick();
    $display("seq halt_mid mem=%0d cpu=%0d", mem_cnt, cpu_cnt);
    check("halt_mid_cpu", cpu_cnt, 1);
    check("halt_mid_no_mem", mem_cnt, 0);
    check("halt_mid_running", int'(running), 0);

    // Reset in the middle of a burst aborts everything.
    do_reset();
    mode      = 3'd3;
    burst_len = 8'd20;
    n = 0;
    while (cpu_cnt < 2 && n < 100) begin
      button = (n < 8) ? 1'b0 : 1'b1;
      tick();
      n++;
    end
    check("rst_burst_started", int'(running), 1);
    RST = 1'b1;
    tick();
    $display("seq rst_mid mem=%0d cpu=%0d run=%0d sc=%0d", mem_ce, cpu_ce, running, step_count);
    check("rst_mid_mem", int'(mem_ce), 0);
    check("rst_mid_cpu", int'(cpu_ce), 0);
    check("rst_mid_running", int'(running), 0);
    check("rst_mid_step_count", int'(step_count), 0);
    RST     = 1'b0;
    mode    = 3'd4;
    button  = 1'b1;
    mem_cnt = 0;
    cpu_cnt = 0;
    repeat (10) tick();
    check("rst_after_pulses", mem_cnt + cpu_cnt, 0);

    check("no_overlap", overlap_cnt, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
